bus_region_decoder: RTL and testbench
=====================================

// Module: bus_region_decoder
// PURPOSE
//  Parametrised, registered Z80 address decoder with per-region wait-state insertion.
//  Replaces fixed combinational decode; one instance per CPU (main and sound).
//  Region table is parameters; memory and I/O regions are decoded by one block.
//  Drives one-hot selects, data-phase strobes, WAIT_n and an unmapped-access counter.
// PARAMETERS
//  AW         16      address width
//  NREG       16      number of regions; index 0 = highest priority
//  REG_BASE   0       NREG*AW packed; inclusive base, region i at [i*AW +: AW]
//  REG_LIMIT  0       NREG*AW packed; exclusive upper bound
//  REG_IO     0       NREG bits; 1 = I/O region, compares ab[7:0] against low bytes
//  WSW        4       wait-state count width
//  REG_WS     0       NREG*WSW packed; wait states inserted per region
// PORTS
//  clk_sys    in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  cen        in   1        CPU clock enable; all CPU-cycle timing advances only on cen
//  ab         in   AW       CPU address bus
//  mreq_n     in   1        memory request
//  iorq_n     in   1        I/O request
//  m1_n       in   1        M1; iorq_n=0 with m1_n=0 (int ack) is never decoded
//  rd_n       in   1        read strobe
//  wr_n       in   1        write strobe
//  sel        out  NREG     registered one-hot region select; held for the whole access
//  hit        out  1        OR of sel
//  wait_n     out  1        to CPU WAIT_n
//  rd_stb     out  1        one clk_sys pulse at data-phase start of a read
//  wr_stb     out  1        one clk_sys pulse at data-phase start of a write
//  miss       out  1        one clk_sys pulse when an access matches no region
//  miss_cnt   out  8        saturating count of misses
// BEHAVIOUR
//  Reset: sel=0, hit=0, wait_n=1, rd_stb=wr_stb=miss=0, miss_cnt=0, state=IDLE.
//  Request: req = (~mreq_n | (~iorq_n & m1_n)) & (~rd_n | ~wr_n).
//  Memory space when mreq_n=0; if mreq_n and iorq_n are both 0, memory space wins.
//  Match i: space(i) == current space & base_i <= key < limit_i (unsigned).
//    Key is ab for memory regions and ab[7:0] for I/O regions.
//    A region with limit <= base never matches.
//  Priority: the lowest matching index wins; sel stays strictly one-hot or zero.
//  FSM is IDLE -> WAIT -> HOLD -> IDLE.
//  IDLE, on cen & req:
//    latch sel; latch dir = ~wr_n (write wins if rd_n and wr_n are both low).
//    If latched ws > 0: wait_n=0, cnt=ws-1, go to WAIT.
//    Otherwise go straight to HOLD.
//  WAIT:
//    On each cen: if cnt==0 then wait_n=1 and go to HOLD, else cnt--.
//    So exactly ws cen periods of wait_n=0.
//  HOLD:
//    rd_stb or wr_stb (per dir) pulses on the first clk_sys cycle of HOLD.
//    Stays in HOLD while req=1; ab changes are ignored.
//    On the clk_sys cycle req=0 is seen (cen not required): sel=0, go to IDLE.
//  Miss:
//    IDLE with req and no match -> sel=0; miss pulses one cycle.
//    miss_cnt++ saturating at 255; no wait; go to HOLD, no rd_stb/wr_stb.
//  req dropping during WAIT (CPU reset): abort to IDLE, wait_n=1, sel=0, no strobe.
//  reset in any state: all outputs take reset values on the next clock.
//  Latency:
//    sel valid 1 clk_sys after the qualifying cen edge.
//    strobe follows (ws cen periods + 1 clk_sys) after that edge.
// STRUCTURE
//  bus_dec_pkg: state enum (IDLE/WAIT/HOLD).
//  bus_dec_pkg: region descriptor pack/unpack functions (base/limit/io/ws by index).
//  bus_dec_pkg: memory-map localparams for the main and sound CPUs.
//  Sub-module region_match: one comparator per region (base, limit, io, key) -> match.
//    Generated NREG times; priority encode plus FSM in the top level.
// TESTING
//  1 Map r0=[0000,4000) ws0, r1=[4000,6000) ws2; read 0x1234 -> sel=0x0001 next clk,
//    wait_n stays 1, rd_stb one pulse.
//  2 Write 0x5000 -> sel=0x0002, wait_n low exactly 2 cen periods,
//    wr_stb after release, sel=0 when wr_n rises.
//  3 I/O r2=[40,41) ws1, r3=[80,81); iorq_n=0, ab=0xFF40 -> sel=0x0004.
//    The same access with m1_n=0 -> no sel, no miss.
//  4 Overlap r4=[B500,B508), r5=[B000,C000); read 0xB503 -> sel=0x0010.
//    Read 0xB600 -> sel=0x0020.
//  5 Read 0x7000 (unmapped) 300 times -> miss pulses each time, miss_cnt saturates 255,
//    rd_stb never pulses.
//  6 reset asserted mid-WAIT, then req dropped mid-WAIT
//    -> wait_n=1 and sel=0 next clk, FSM IDLE, no strobe.

Source files
------------

// File: rtl/bus_dec_pkg.sv
// Shared state encoding, region helpers and memory maps
// for the Z80 bus region decoder.
package bus_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam int MAP_AW   = 16;
  localparam int MAP_NREG = 16;
  localparam int MAP_WSW  = 4;

  typedef struct packed {
    logic [MAP_AW-1:0]  base;
    logic [MAP_AW-1:0]  limit;
    logic               io;
    logic [MAP_WSW-1:0] ws;
  } region_t;

  function automatic region_t rgn_get(
    input logic [MAP_NREG*MAP_AW-1:0]  base_v,
    input logic [MAP_NREG*MAP_AW-1:0]  limit_v,
    input logic [MAP_NREG-1:0]         io_v,
    input logic [MAP_NREG*MAP_WSW-1:0] ws_v,
    input int                          idx
  );
    region_t r;
    r.base  = base_v[idx*MAP_AW +: MAP_AW];
    r.limit = limit_v[idx*MAP_AW +: MAP_AW];
    r.io    = io_v[idx];
    r.ws    = ws_v[idx*MAP_WSW +: MAP_WSW];
    return r;
  endfunction

  function automatic logic [MAP_NREG*MAP_AW-1:0] rgn_put(
    input logic [MAP_NREG*MAP_AW-1:0] v,
    input int                         idx,
    input logic [MAP_AW-1:0]          x
  );
    logic [MAP_NREG*MAP_AW-1:0] r;
    r = v;
    r[idx*MAP_AW +: MAP_AW] = x;
    return r;
  endfunction

  // Main CPU: ROM, work RAM, video RAM, I/O ports 00-0F
  localparam logic [255:0] MAIN_BASE = {
    {12{16'h0000}}, 16'h0000, 16'hC000, 16'h8000, 16'h0000};
  localparam logic [255:0] MAIN_LIMIT = {
    {12{16'h0000}}, 16'h0010, 16'hD000, 16'hC000, 16'h8000};
  localparam logic [15:0]  MAIN_IO = 16'h0008;
  localparam logic [63:0]  MAIN_WS = {
    {12{4'h0}}, 4'h1, 4'h2, 4'h1, 4'h0};

  // Sound CPU: ROM, RAM, I/O ports 00-03
  localparam logic [255:0] SND_BASE = {
    {13{16'h0000}}, 16'h0000, 16'h4000, 16'h0000};
  localparam logic [255:0] SND_LIMIT = {
    {13{16'h0000}}, 16'h0004, 16'h4800, 16'h4000};
  localparam logic [15:0]  SND_IO = 16'h0004;
  localparam logic [63:0]  SND_WS = {
    {13{4'h0}}, 4'h1, 4'h0, 4'h0};

endpackage

// File: rtl/region_match.sv
// Single region comparator: space match plus
// inclusive base / exclusive limit range test.
module region_match #(
  parameter int          AW    = 16,
  parameter logic [AW-1:0] BASE  = '0,
  parameter logic [AW-1:0] LIMIT = '0,
  parameter bit          IO    = 1'b0
) (
  input  logic [AW-1:0] i_ab,
  input  logic          i_io_space,
  output logic          o_match
);

  logic w_mem_hit;
  logic w_io_hit;

  assign w_mem_hit = (i_ab >= BASE) && (i_ab < LIMIT);

  // I/O ports only decode the low address byte
  assign w_io_hit = (i_ab[7:0] >= BASE[7:0]) &&
                    (i_ab[7:0] < LIMIT[7:0]);

  assign o_match = (i_io_space == IO) &&
                   (IO ? w_io_hit : w_mem_hit);

endmodule

// File: rtl/bus_region_decoder.sv
// Registered Z80 region decoder with per-region
// wait-state insertion, data strobes and miss count.
module bus_region_decoder
  import bus_dec_pkg::*;
#(
  parameter int                  AW        = 16,
  parameter int                  NREG      = 16,
  parameter int                  WSW       = 4,
  parameter logic [NREG*AW-1:0]  REG_BASE  = '0,
  parameter logic [NREG*AW-1:0]  REG_LIMIT = '0,
  parameter logic [NREG-1:0]     REG_IO    = '0,
  parameter logic [NREG*WSW-1:0] REG_WS    = '0
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            cen,
  input  logic [AW-1:0]   ab,
  input  logic            mreq_n,
  input  logic            iorq_n,
  input  logic            m1_n,
  input  logic            rd_n,
  input  logic            wr_n,
  output logic [NREG-1:0] sel,
  output logic            hit,
  output logic            wait_n,
  output logic            rd_stb,
  output logic            wr_stb,
  output logic            miss,
  output logic [7:0]      miss_cnt
);

  logic            w_req;
  logic            w_io_space;
  logic [NREG-1:0] w_match;
  logic [NREG-1:0] w_sel;
  logic [WSW-1:0]  w_ws;
  logic            w_found;

  state_t          r_state;
  logic [NREG-1:0] r_sel;
  logic            r_wait_n;
  logic            r_rd_stb;
  logic            r_wr_stb;
  logic            r_miss;
  logic [7:0]      r_miss_cnt;
  logic [WSW-1:0]  r_cnt;
  logic            r_wr;

  // Interrupt acknowledge (iorq with m1) never decodes
  assign w_req = (~mreq_n | (~iorq_n & m1_n)) & (~rd_n | ~wr_n);
  assign w_io_space = mreq_n;

  for (genvar g = 0; g < NREG; g++) begin : g_rgn
    region_match #(
      .AW    (AW),
      .BASE  (REG_BASE[g*AW +: AW]),
      .LIMIT (REG_LIMIT[g*AW +: AW]),
      .IO    (REG_IO[g])
    ) u_match (
      .i_ab       (ab),
      .i_io_space (w_io_space),
      .o_match    (w_match[g])
    );
  end

  always_comb begin
    w_sel   = '0;
    w_ws    = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (w_match[i] && !w_found) begin
        w_found  = 1'b1;
        w_sel[i] = 1'b1;
        w_ws     = REG_WS[i*WSW +: WSW];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_wait_n   <= 1'b1;
      r_rd_stb   <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_miss     <= 1'b0;
      r_miss_cnt <= '0;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
    end else begin
      r_rd_stb <= 1'b0;
      r_wr_stb <= 1'b0;
      r_miss   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (cen && w_req) begin
            r_sel <= w_sel;
            r_wr  <= ~wr_n;
            if (!w_found) begin
              r_miss  <= 1'b1;
              r_state <= ST_HOLD;
              if (r_miss_cnt != 8'hFF)
                r_miss_cnt <= r_miss_cnt + 8'd1;
            end else if (w_ws != '0) begin
              r_wait_n <= 1'b0;
              r_cnt    <= w_ws - WSW'(1);
              r_state  <= ST_WAIT;
            end else begin
              r_wr_stb <= ~wr_n;
              r_rd_stb <= wr_n;
              r_state  <= ST_HOLD;
            end
          end
        end
        ST_WAIT: begin
          // A vanishing request here means the CPU was reset
          if (!w_req) begin
            r_wait_n <= 1'b1;
            r_sel    <= '0;
            r_state  <= ST_IDLE;
          end else if (cen) begin
            if (r_cnt == '0) begin
              r_wait_n <= 1'b1;
              r_wr_stb <= r_wr;
              r_rd_stb <= ~r_wr;
              r_state  <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt - WSW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!w_req) begin
            r_sel   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel      = r_sel;
  assign hit      = |r_sel;
  assign wait_n   = r_wait_n;
  assign rd_stb   = r_rd_stb;
  assign wr_stb   = r_wr_stb;
  assign miss     = r_miss;
  assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Randomized and directed bench for bus_region_decoder
// against a transaction-level reference model.
module tb_bus_region_decoder;

  // r0 [0000,4000) ws0   r1 [4000,6000) ws2   r2 io [40,41) ws1
  // r3 io [80,81) ws0    r4 [B500,B508) ws3   r5 [B000,C000) ws1
  // r6 empty (limit<base) r7 io [10,20) ws5   r8 [F000,FFFF) ws4
  localparam logic [255:0] P_BASE = {{7{16'h0000}},
    16'hF000, 16'h0010, 16'hD000, 16'hB000, 16'hB500,
    16'h0080, 16'h0040, 16'h4000, 16'h0000};
  localparam logic [255:0] P_LIM = {{7{16'h0000}},
    16'hFFFF, 16'h0020, 16'hC000, 16'hC000, 16'hB508,
    16'h0081, 16'h0041, 16'h6000, 16'h4000};
  localparam logic [15:0] P_IO = 16'h008C;
  localparam logic [63:0] P_WS = {{7{4'h0}},
    4'h4, 4'h5, 4'h0, 4'h1, 4'h3, 4'h0, 4'h1, 4'h2, 4'h0};

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        cen     = 1'b1;
  logic [15:0] ab      = '0;
  logic        mreq_n  = 1'b1;
  logic        iorq_n  = 1'b1;
  logic        m1_n    = 1'b1;
  logic        rd_n    = 1'b1;
  logic        wr_n    = 1'b1;
  logic [15:0] sel;
  logic        hit, wait_n, rd_stb, wr_stb, miss;
  logic [7:0]  miss_cnt;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit cen_rand = 1'b0;

  logic [15:0] a_first, a_after;
  int a_rd, a_wr, a_miss, a_wlow;

  logic [15:0] m_sel = '0;
  bit m_wait = 1'b1, m_rd = 1'b0, m_wr = 1'b0, m_miss = 1'b0;
  bit m_busy = 1'b0, m_dir = 1'b0;
  int m_cnt = 0, m_left = 0;

  bus_region_decoder #(
    .AW(16), .NREG(16), .WSW(4),
    .REG_BASE(P_BASE), .REG_LIMIT(P_LIM),
    .REG_IO(P_IO), .REG_WS(P_WS)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .cen(cen), .ab(ab),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n),
    .rd_n(rd_n), .wr_n(wr_n), .sel(sel), .hit(hit),
    .wait_n(wait_n), .rd_stb(rd_stb), .wr_stb(wr_stb),
    .miss(miss), .miss_cnt(miss_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] base_of(input int i);
    return P_BASE[i*16 +: 16];
  endfunction
  function automatic logic [15:0] lim_of(input int i);
    return P_LIM[i*16 +: 16];
  endfunction
  function automatic int ws_of(input int i);
    return int'(P_WS[i*4 +: 4]);
  endfunction

  function automatic int lookup(input logic [15:0] a, input bit io);
    for (int i = 0; i < 16; i++) begin
      int key, lo, hi;
      key = int'(a);
      lo  = int'(base_of(i));
      hi  = int'(lim_of(i));
      if (io) begin
        key = key % 256;
        lo  = lo % 256;
        hi  = hi % 256;
      end
      if (P_IO[i] == io && key >= lo && key < hi) return i;
    end
    return -1;
  endfunction

  // Reference: one access = decode, ws cen periods of wait, strobe, hold
  initial forever begin
    bit req;
    int idx;
    @(posedge clk_sys);
    req = (!mreq_n || (!iorq_n && m1_n)) && (!rd_n || !wr_n);
    m_rd = 1'b0;
    m_wr = 1'b0;
    m_miss = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_left = 0; m_sel = '0;
      m_wait = 1'b1; m_cnt = 0;
    end else if (!m_busy) begin
      if (cen && req) begin
        idx = lookup(ab, mreq_n);
        m_busy = 1'b1;
        m_dir = !wr_n;
        m_sel = '0;
        if (idx < 0) begin
          m_miss = 1'b1;
          m_left = 0;
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_sel[idx] = 1'b1;
          m_left = ws_of(idx);
          if (m_left == 0) begin
            m_wr = m_dir; m_rd = !m_dir;
          end else m_wait = 1'b0;
        end
      end
    end else if (m_left > 0) begin
      if (!req) begin
        m_busy = 1'b0; m_left = 0; m_wait = 1'b1; m_sel = '0;
      end else if (cen) begin
        m_left--;
        if (m_left == 0) begin
          m_wait = 1'b1; m_wr = m_dir; m_rd = !m_dir;
        end
      end
    end else if (!req) begin
      m_busy = 1'b0; m_sel = '0;
    end
  end

  initial forever begin
    @(negedge clk_sys);
    if (chk_en) begin
      check("sel", 32'(sel), 32'(m_sel));
      check("hit", 32'(hit), 32'(|m_sel));
      check("wait_n", 32'(wait_n), 32'(m_wait));
      check("rd_stb", 32'(rd_stb), 32'(m_rd));
      check("wr_stb", 32'(wr_stb), 32'(m_wr));
      check("miss", 32'(miss), 32'(m_miss));
      check("miss_cnt", 32'(miss_cnt), 32'(m_cnt));
    end
  end

  initial forever begin
    @(negedge clk_sys);
    cen = cen_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // kind: 0 memory, 1 I/O, 2 interrupt acknowledge
  task automatic drive(input logic [15:0] a, input int kind,
                       input bit wr);
    ab = a;
    mreq_n = (kind != 0);
    iorq_n = (kind == 0);
    m1_n = (kind != 2);
    rd_n = wr;
    wr_n = ~wr;
  endtask

  task automatic idle_bus();
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic sample();
    @(negedge clk_sys);
    a_rd += int'(rd_stb);
    a_wr += int'(wr_stb);
    a_miss += int'(miss);
    if (!wait_n) a_wlow++;
  endtask

  task automatic access(input logic [15:0] a, input int kind,
                        input bit wr, input int hold);
    a_rd = 0; a_wr = 0; a_miss = 0; a_wlow = 0;
    @(negedge clk_sys);
    drive(a, kind, wr);
    sample();
    a_first = sel;
    repeat (hold - 1) sample();
    idle_bus();
    sample();
    a_after = sel;
    sample();
  endtask

  initial begin
    int tot_miss, tot_rd;
    repeat (3) @(negedge clk_sys);
    chk_en = 1'b1;
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_wait", 32'(wait_n), 32'h1);
    check("rst_cnt", 32'(miss_cnt), 32'h0);
    reset = 1'b0;

    access(16'h1234, 0, 1'b0, 4);
    check("t1_sel", 32'(a_first), 32'h0001);
    check("t1_wlow", 32'(a_wlow), 32'd0);
    check("t1_rd", 32'(a_rd), 32'd1);

    access(16'h5000, 0, 1'b1, 6);
    check("t2_sel", 32'(a_first), 32'h0002);
    check("t2_wlow", 32'(a_wlow), 32'd2);
    check("t2_wr", 32'(a_wr), 32'd1);
    check("t2_rd", 32'(a_rd), 32'd0);
    check("t2_rel", 32'(a_after), 32'h0);

    access(16'hFF40, 1, 1'b0, 5);
    check("t3_sel", 32'(a_first), 32'h0004);
    check("t3_wlow", 32'(a_wlow), 32'd1);
    access(16'hFF40, 2, 1'b0, 5);
    check("t3_ack_sel", 32'(a_first), 32'h0);
    check("t3_ack_miss", 32'(a_miss), 32'd0);

    access(16'hB503, 0, 1'b0, 8);
    check("t4_inner", 32'(a_first), 32'h0010);
    check("t4_wlow", 32'(a_wlow), 32'd3);
    access(16'hB600, 0, 1'b0, 8);
    check("t4_outer", 32'(a_first), 32'h0020);

    tot_miss = 0;
    tot_rd = 0;
    for (int i = 0; i < 300; i++) begin
      access(16'h7000, 0, 1'b0, 2);
      tot_miss += a_miss;
      tot_rd += a_rd;
    end
    check("t5_pulses", 32'(tot_miss), 32'd300);
    check("t5_rd", 32'(tot_rd), 32'd0);
    check("t5_sat", 32'(miss_cnt), 32'd255);

    a_wr = 0;
    @(negedge clk_sys);
    drive(16'hF800, 0, 1'b1);
    @(negedge clk_sys);
    check("t6_inwait", 32'(wait_n), 32'h0);
    reset = 1'b1;
    @(negedge clk_sys);
    check("t6r_wait", 32'(wait_n), 32'h1);
    check("t6r_sel", 32'(sel), 32'h0);
    check("t6r_cnt", 32'(miss_cnt), 32'h0);
    check("t6r_stb", 32'(wr_stb), 32'h0);
    reset = 1'b0;
    idle_bus();
    repeat (2) @(negedge clk_sys);

    a_rd = 0;
    drive(16'hF800, 0, 1'b0);
    sample();
    sample();
    check("t6d_inwait", 32'(wait_n), 32'h0);
    idle_bus();
    sample();
    check("t6d_wait", 32'(wait_n), 32'h1);
    check("t6d_sel", 32'(sel), 32'h0);
    repeat (4) sample();
    check("t6d_nostb", 32'(a_rd), 32'd0);

    cen_rand = 1'b1;
    for (int t = 0; t < 400; t++) begin
      int gap, hold, kind, ri, r;
      logic [15:0] a;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk_sys);
      ri = int'($urandom_range(0, 8));
      case ($urandom_range(0, 4))
        0: a = base_of(ri);
        1: a = lim_of(ri) - 16'd1;
        2: a = lim_of(ri);
        3: a = base_of(ri) - 16'd1;
        default: a = 16'($urandom);
      endcase
      r = int'($urandom_range(0, 9));
      kind = (r < 6) ? 0 : (r < 9) ? 1 : 2;
      @(negedge clk_sys);
      drive(a, kind, 1'($urandom_range(0, 1)));
      if (kind != 0) ab[15:8] = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rd_n = 1'b0; wr_n = 1'b0;
      end
      if (kind == 0 && $urandom_range(0, 9) == 0) iorq_n = 1'b0;
      hold = int'($urandom_range(1, 25));
      for (int k = 0; k < hold; k++) begin
        @(negedge clk_sys);
        if ($urandom_range(0, 3) == 0) ab = 16'($urandom);
        reset = ($urandom_range(0, 59) == 0);
      end
      reset = 1'b0;
      idle_bus();
    end

    repeat (4) @(negedge clk_sys);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
